// File: rtl/mem_copy.sv
// Bus-master block copy engine for the LC-3 memory interface. It copies words
// through MAR/MDR on the shared bus and accumulates a 16-bit checksum.
module mem_copy (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum,
  output logic        bus_req,
  input  logic        bus_gnt,
  inout  wire  [15:0] bus,
  input  logic        mem_rdy,
  output logic        mem_ld_mar,
  output logic        mem_ld_mdr,
  output logic        mem_gate_mdr,
  output logic        mem_mio_en,
  output logic        mem_rw
);

  typedef enum logic [3:0] {
    IDLE, REQ, LD_SRC, RD, SUM, LD_DST, WR, NEXT, DONE
  } state_t;

  state_t      state, state_next;
  logic [15:0] src_q, dst_q, rem_q, sum_q;
  logic        drive_en;
  logic [15:0] drive_val;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q <= src_addr;
          dst_q <= dst_addr;
          rem_q <= count;
          sum_q <= '0;
        end
        SUM:  sum_q <= sum_q + bus;
        NEXT: begin
          src_q <= src_q + 16'd1;
          dst_q <= dst_q + 16'd1;
          rem_q <= rem_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (count == 16'd0) ? DONE : REQ;
      REQ:     if (bus_gnt) state_next = LD_SRC;
      LD_SRC:  state_next = RD;
      RD:      if (mem_rdy) state_next = SUM;
      SUM:     state_next = LD_DST;
      LD_DST:  state_next = WR;
      WR:      if (mem_rdy) state_next = NEXT;
      // rem_q still holds the pre-decrement value here
      NEXT:    if (rem_q == 16'd1) state_next = DONE;
               else if (bus_gnt)   state_next = LD_SRC;
               else                state_next = REQ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    bus_req      = 1'b0;
    mem_ld_mar   = 1'b0;
    mem_ld_mdr   = 1'b0;
    mem_gate_mdr = 1'b0;
    mem_mio_en   = 1'b0;
    mem_rw       = 1'b0;
    drive_en     = 1'b0;
    drive_val    = '0;
    case (state)
      REQ:    bus_req = 1'b1;
      LD_SRC: begin
        bus_req    = 1'b1;
        mem_ld_mar = 1'b1;
        drive_en   = 1'b1;
        drive_val  = src_q;
      end
      RD: begin
        bus_req    = 1'b1;
        mem_mio_en = 1'b1;
        mem_ld_mdr = 1'b1;
      end
      SUM: begin
        bus_req      = 1'b1;
        mem_gate_mdr = 1'b1;
      end
      LD_DST: begin
        bus_req    = 1'b1;
        mem_ld_mar = 1'b1;
        drive_en   = 1'b1;
        drive_val  = dst_q;
      end
      WR: begin
        bus_req    = 1'b1;
        mem_mio_en = 1'b1;
        mem_rw     = 1'b1;
      end
      NEXT:    bus_req = 1'b1;
      default: ;
    endcase
  end

  assign bus      = drive_en ? drive_val : 16'hzzzz;
  assign checksum = sum_q;

endmodule

// File: tb/tb_mem_copy.sv
// Bench for mem_copy: LC-3 style memory model on the shared bus, random and
// directed copies checked against a word-by-word reference of the copy rules.
module tb_mem_copy;

  logic        clk = 1'b0;
  logic        rst, start, bus_gnt, mem_rdy;
  logic [15:0] src_addr, dst_addr, count, checksum;
  logic        busy, done, bus_req;
  logic        mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw;
  wire  [15:0] bus;

  always #5 clk = ~clk;

  mem_copy dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .busy(busy), .done(done), .checksum(checksum),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus(bus), .mem_rdy(mem_rdy),
    .mem_ld_mar(mem_ld_mar), .mem_ld_mdr(mem_ld_mdr), .mem_gate_mdr(mem_gate_mdr),
    .mem_mio_en(mem_mio_en), .mem_rw(mem_rw)
  );

  // memory model: MAR/MDR with a programmable number of wait cycles per access
  logic [15:0] ram [0:65535];
  logic [15:0] shadow [0:65535];
  logic [15:0] mar = '0, mdr = '0;
  int          wait_n = 0, wcnt = 0;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0, poke_data = '0;
  logic        cpu_en = 1'b0;
  logic [15:0] cpu_val = '0;

  assign mem_rdy = (wcnt == 0);
  assign bus = mem_gate_mdr ? mdr : 16'hzzzz;
  assign bus = cpu_en ? cpu_val : 16'hzzzz;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_mio_en && mem_rdy && mem_rw) ram[mar] <= mdr;
    if (mem_ld_mar) mar <= bus;
    if (mem_mio_en && mem_rdy && !mem_rw && mem_ld_mdr) mdr <= ram[mar];
    if (mem_mio_en && !mem_rdy) wcnt <= wcnt - 1;
    else                        wcnt <= wait_n;
  end

  int rd_cyc = 0, wr_cyc = 0, gate_cyc = 0, mar_cyc = 0, req_cyc = 0, mem_cyc = 0;
  always @(posedge clk) begin
    if (mem_mio_en && !mem_rw && mem_ld_mdr) rd_cyc <= rd_cyc + 1;
    if (mem_mio_en && mem_rw) wr_cyc <= wr_cyc + 1;
    if (mem_gate_mdr) gate_cyc <= gate_cyc + 1;
    if (mem_ld_mar) mar_cyc <= mar_cyc + 1;
    if (bus_req) req_cyc <= req_cyc + 1;
    if (mem_ld_mar || mem_ld_mdr || mem_gate_mdr || mem_mio_en || mem_rw) mem_cyc <= mem_cyc + 1;
  end

  int vecs = 0, errs = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    shadow[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic fill(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) poke(s + 16'(i), 16'($urandom));
  endtask

  // a CPU-side driver that must win the bus cleanly when the engine is hi-Z
  task automatic check_hiz(input string tag);
    cpu_val = 16'($urandom) | 16'h8421;
    cpu_en  = 1'b1;
    #1;
    check_val(tag, 32'(bus), 32'(cpu_val));
    cpu_en  = 1'b0;
  endtask

  task automatic check_mem_idle(input string tag);
    check_val(tag, 32'({bus_req, mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw}), 32'd0);
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    @(negedge clk);
    src_addr = s; dst_addr = d; count = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat = number of edges from the start edge up to the edge that samples done
  task automatic wait_done(input int max, input bit mid, output int lat);
    lat = 0;
    forever begin
      lat++;
      if (done) break;
      if (lat > max) begin
        check_val("done_timeout", 32'(done), 32'd1);
        break;
      end
      if (mid && lat == 3) begin
        start = 1'b1; src_addr = 16'($urandom); count = 16'd5;
      end
      if (mid && lat == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // reference: ascending word-by-word copy, so overlapping ranges propagate
  task automatic reference(input logic [15:0] s, input logic [15:0] d, input int n,
                           output logic [15:0] sum);
    sum = '0;
    for (int i = 0; i < n; i++) begin
      shadow[d + 16'(i)] = shadow[s + 16'(i)];
      sum = sum + shadow[s + 16'(i)];
    end
  endtask

  task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input int n, input int wn, input bit mid, output logic [15:0] sum);
    int lat, rd0, wr0, gate0, mar0;
    int exp_lat;
    wait_n = wn;
    poke(d + 16'(n), 16'($urandom));
    reference(s, d, n, sum);
    exp_lat = 2 + n * (6 + 2 * wn);
    rd0 = rd_cyc; wr0 = wr_cyc; gate0 = gate_cyc; mar0 = mar_cyc;
    pulse_start(s, d, 16'(n));
    wait_done(exp_lat + 20, mid, lat);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_checksum"}, 32'(checksum), 32'(sum));
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check_val({tag, "_rd_cycles"}, 32'(rd_cyc - rd0), 32'(n * (1 + wn)));
    check_val({tag, "_wr_cycles"}, 32'(wr_cyc - wr0), 32'(n * (1 + wn)));
    check_val({tag, "_gate_cycles"}, 32'(gate_cyc - gate0), 32'(n));
    check_val({tag, "_mar_loads"}, 32'(mar_cyc - mar0), 32'(2 * n));
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    check_val({tag, "_checksum_held"}, 32'(checksum), 32'(sum));
    check_hiz({tag, "_bus_idle"});
    for (int i = 0; i <= n; i++)
      check_val({tag, "_dst_word"}, 32'(ram[d + 16'(i)]), 32'(shadow[d + 16'(i)]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sum, s, d, old1;
    int          lat, n, req0, mem0, cyc;
    rst = 1'b1; start = 1'b0; bus_gnt = 1'b1;
    src_addr = '0; dst_addr = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy_done", 32'({busy, done}), 32'd0);
    check_mem_idle("reset_mem");
    check_val("reset_checksum", 32'(checksum), 32'd0);
    check_hiz("reset_bus");
    @(negedge clk); rst = 1'b0;

    // 4 words with a 0xFFFF term
    poke(16'h3000, 16'h0001); poke(16'h3001, 16'h0002);
    poke(16'h3002, 16'h0003); poke(16'h3003, 16'hFFFF);
    run_copy("blk4", 16'h3000, 16'h4000, 4, 0, 1'b0, sum);
    check_val("blk4_checksum_value", 32'(checksum), 32'h0005);

    // count = 0: done immediately, no bus traffic, checksum cleared
    req0 = req_cyc; mem0 = mem_cyc;
    pulse_start(16'h1234, 16'h5678, 16'd0);
    check_val("cnt0_done", 32'({done, busy}), 32'b11);
    check_val("cnt0_checksum", 32'(checksum), 32'd0);
    @(posedge clk); #1;
    check_val("cnt0_after", 32'({done, busy}), 32'd0);
    check_val("cnt0_bus_req", 32'(req_cyc - req0), 32'd0);
    check_val("cnt0_mem", 32'(mem_cyc - mem0), 32'd0);

    // source address wraps 0xFFFF -> 0x0000
    poke(16'hFFFF, 16'hAAAA); poke(16'h0000, 16'h5555);
    run_copy("wrap", 16'hFFFF, 16'h5000, 2, 0, 1'b0, sum);
    check_val("wrap_checksum_value", 32'(checksum), 32'hFFFF);

    // three wait cycles on every access
    fill(16'h6000, 2);
    run_copy("wait3", 16'h6000, 16'h7000, 2, 3, 1'b0, sum);

    // grant removed during the first write
    fill(16'h0100, 3);
    poke(16'h0203, 16'($urandom));
    reference(16'h0100, 16'h0200, 3, sum);
    wait_n = 0;
    pulse_start(16'h0100, 16'h0200, 16'd3);
    cyc = 0;
    while (!(mem_mio_en && mem_rw) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check_val("gnt_reach_wr", 32'(mem_mio_en && mem_rw), 32'd1);
    bus_gnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("gnt_lost_req", 32'({bus_req, busy}), 32'b11);
    check_val("gnt_lost_mem", 32'({mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw}), 32'd0);
    check_val("gnt_word0", 32'(ram[16'h0200]), 32'(shadow[16'h0200]));
    check_hiz("gnt_lost_bus");
    @(negedge clk); bus_gnt = 1'b1;
    wait_done(40, 1'b0, lat);
    check_val("gnt_checksum", 32'(checksum), 32'(sum));
    for (int i = 0; i < 4; i++)
      check_val("gnt_dst_word", 32'(ram[16'h0200 + 16'(i)]), 32'(shadow[16'h0200 + 16'(i)]));

    // reset during the read of word 1
    fill(16'h1000, 3);
    poke(16'h2000, 16'($urandom)); poke(16'h2001, 16'($urandom));
    old1 = shadow[16'h2001];
    wait_n = 1;
    n = mar_cyc;
    pulse_start(16'h1000, 16'h2000, 16'd3);
    cyc = 0;
    while (!(mem_mio_en && !mem_rw && (mar_cyc - n) == 3) && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    check_val("rst_reach_rd1", 32'(mar_cyc - n), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_busy_done", 32'({busy, done}), 32'd0);
    check_mem_idle("rst_mem");
    check_val("rst_checksum", 32'(checksum), 32'd0);
    check_hiz("rst_bus");
    check_val("rst_word0", 32'(ram[16'h2000]), 32'(shadow[16'h1000]));
    check_val("rst_word1", 32'(ram[16'h2001]), 32'(old1));
    shadow[16'h2000] = shadow[16'h1000];
    @(negedge clk); rst = 1'b0;
    fill(16'h1100, 2);
    run_copy("post_rst", 16'h1100, 16'h2100, 2, 0, 1'b0, sum);

    // randomized copies, including dst = src + 1 overlap and ignored restarts
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 8);
      s = 16'($urandom);
      d = (it % 3 == 0) ? s + 16'd1 : 16'($urandom);
      fill(s, n);
      run_copy("rand", s, d, n, $urandom_range(0, 2), it[0], sum);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_copy.md
# mem_copy

Bus-master copy engine for the LC-3 memory interface. It copies a block of words within memory by driving the same MAR/MDR control set as the CPU (ld_mar, ld_mdr, gate_mdr, mio_en, rw, honouring rdy). It shares the 16-bit tri-state system bus with the CPU through a req/gnt pair and accumulates a 16-bit checksum of the copied words. Typical uses are boot-time image relocation and test-bench preloading without touching the RAM array directly.

## Interface
- No parameters; data and address width are fixed at 16.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  16  first source word address, latched on accepted start
- dst_addr  in  16  first destination word address, latched on accepted start
- count  in  16  number of words to copy, latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse at completion
- checksum  out  16  modulo-2^16 sum of all words copied; held until the next accepted start
- bus_req  out  1  bus request to arbiter
- bus_gnt  in  1  grant; while high the CPU must not drive the bus or memory controls
- bus  inout  16  shared system bus; driven only in LD_SRC/LD_DST, hi-Z otherwise
- mem_rdy  in  1  memory ready; a read or write access completes on an edge where rdy=1
- mem_ld_mar  out  1  MAR <= bus at the edge
- mem_ld_mdr  out  1  MDR <= RAM[MAR] at the edge (mio_en=1)
- mem_gate_mdr  out  1  memory drives MDR onto bus
- mem_mio_en  out  1  memory access enable
- mem_rw  out  1  0 = read, 1 = write RAM[MAR] <= MDR

## Operation
- States: IDLE, REQ, LD_SRC, RD, SUM, LD_DST, WR, NEXT, DONE.
- IDLE: start=1 latches src, dst, count and clears checksum.
  - count=0: go to DONE, no bus request.
  - Otherwise: go to REQ.
- REQ: bus_req=1; wait for bus_gnt=1, then go to LD_SRC.
- LD_SRC: drive bus=src, mem_ld_mar=1; go to RD.
- RD: mio_en=1, rw=0, ld_mdr=1; stay while rdy=0; on rdy=1 go to SUM.
- SUM: gate_mdr=1; checksum <= checksum + bus; go to LD_DST.
- LD_DST: drive bus=dst, mem_ld_mar=1. MDR is untouched and still holds the read word. Go to WR.
- WR: mio_en=1, rw=1; stay while rdy=0; on rdy=1 go to NEXT.
- NEXT: src+=1, dst+=1, remaining-=1, all mod 2^16 (0xFFFF wraps to 0x0000).
  - remaining now 0: go to DONE.
  - Else bus_gnt=1: go to LD_SRC.
  - Else: go to REQ.
- DONE: done=1, bus_req=0; go to IDLE.
- bus_req stays high in every state from REQ through NEXT.
- Grant loss: a gnt drop mid-word does not abort that word. Checked only in NEXT.
- start outside IDLE is ignored; inputs are not re-sampled.
- Overlap: copy is strictly ascending, word-by-word. With dst=src+1, src word 0 propagates through the whole range. This is the defined behaviour.
- At most one of the bus drivers (this block, memory via gate_mdr) is active in any cycle; bus is hi-Z in all other states.

## Timing
- Reset (any state, including mid-transfer): next edge → IDLE.
  - busy=0, done=0, bus_req=0, all mem_* outputs=0, bus hi-Z, checksum=0.
  - A word in flight is abandoned; memory contents are whatever the last completed WR left.
- All outputs are Moore, decoded from state only.
- Zero-wait memory (rdy=1): start→bus_req 1 cycle; 6 cycles per word after grant; NEXT→DONE 1 cycle.
  - N words with immediate grant: done asserted 2+6N cycles after the start edge.
- Each rdy=0 cycle in RD or WR adds exactly one cycle.
- count=0: done asserted at the edge after start; busy high for exactly that one cycle.
- checksum is final and stable in the cycle done is high.

## Test plan
- Copy 4 words 0x3000–0x3003 = {0x0001, 0x0002, 0x0003, 0xFFFF} to 0x4000, rdy=1, gnt tied high → RAM[0x4000..0x4003] match, checksum=0x0005, done at start+26 cycles.
- count=0, start=1 → done one cycle later; bus_req never asserted; no mem_* activity.
- src=0xFFFF, dst=0x5000, count=2, RAM[0xFFFF]=0xAAAA, RAM[0x0000]=0x5555 → RAM[0x5000]=0xAAAA, RAM[0x5001]=0x5555, checksum=0xFFFF.
- rdy held low 3 cycles on every RD and WR, 2-word copy → done at 2+2*(6+6)=26 cycles; data correct; ld_mdr/mio_en held throughout RD.
- gnt dropped during WR of word 0 of 3 → word 0 completes; engine returns to REQ with bus hi-Z and all mem_* low; after re-grant, words 1–2 are copied correctly.
- rst asserted during RD of word 1 → next cycle all outputs at reset values and bus hi-Z; destination word 0 written, word 1 not; a new start then runs normally.
